// File: rtl/dot_matrix_pkg.sv
// Shared types and constants for the dot-matrix cursor: FSM state encodings,
// one-hot button directions and a clog2 helper that never returns zero.
package dot_matrix_pkg;

  typedef enum logic [3:0] {
    OFF  = 4'hA,
    INIT = 4'hF,
    RUN  = 4'h5
  } state_t;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_RIGHT = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  // Width needed to index n items; a single item still gets one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dot_matrix_btn_repeat.sv
// Button front end: remembers last cycle's buttons, turns a fresh single-button
// press into a move and keeps producing moves while that button stays held.
module dot_matrix_btn_repeat
  import dot_matrix_pkg::*;
#(
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] dir,
  output logic       move_pulse,
  output logic [3:0] move_dir
);

  localparam int SPAN = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNTW = clog2_min1(SPAN);
  localparam logic [CNTW-1:0] DELAY_LAST = CNTW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNTW-1:0] RATE_LAST  = CNTW'((REPEAT_RATE > 0) ? REPEAT_RATE - 1 : 0);
  localparam bit REPEAT_ON = (REPEAT_DELAY > 0);

  logic [3:0]      prev_dir;
  logic [CNTW-1:0] cnt;
  logic            armed;      // a real press started the current hold
  logic            repeating;  // first repeat done, now pacing at REPEAT_RATE
  logic            dir_valid;
  logic            press;
  logic            held;
  logic            hit;

  // NOTE: every signal gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dir_valid  = 1'b0;
    press      = 1'b0;
    held       = 1'b0;
    hit        = 1'b0;
    move_pulse = 1'b0;
    move_dir   = dir;
    case (dir)
      DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT: dir_valid = 1'b1;
      default:                               dir_valid = 1'b0;
    endcase
    press      = enable && dir_valid && (dir != prev_dir);
    held       = enable && dir_valid && (dir == prev_dir) && armed && REPEAT_ON;
    hit        = held && (repeating ? (cnt == RATE_LAST) : (cnt == DELAY_LAST));
    move_pulse = press || hit;
  end

  // NOTE: prev_dir is deliberately left out of reset: it reloads from the
  // buttons on every edge in every state, so a reset would add nothing.
  always_ff @(posedge clk) begin
    prev_dir <= dir;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || !enable || !dir_valid) begin
      cnt       <= '0;
      armed     <= 1'b0;
      repeating <= 1'b0;
    end else if (press) begin
      cnt       <= '0;
      armed     <= 1'b1;
      repeating <= 1'b0;
    end else if (hit) begin
      cnt       <= '0;
      repeating <= 1'b1;
    end else if (held) begin
      cnt       <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dot_matrix_cursor.sv
// Single lit dot on a ROWS x COLS LED matrix, steered by four debounced buttons
// with hold-to-repeat and wrap-or-clamp edges; power low blanks everything.
module dot_matrix_cursor
  import dot_matrix_pkg::*;
#(
  parameter  int ROWS         = 8,
  parameter  int COLS         = 8,
  parameter  int WRAP         = 1,
  parameter  int REPEAT_DELAY = 16,
  parameter  int REPEAT_RATE  = 4,
  localparam int RW           = clog2_min1(ROWS),
  localparam int CW           = clog2_min1(COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 power,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  output logic [ROWS*COLS-1:0] mat_out,
  output logic [RW-1:0]        row_pos,
  output logic [CW-1:0]        col_pos,
  output logic                 active
);

  localparam int NDOTS = ROWS * COLS;
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       dir;
  logic             move_pulse;
  logic [3:0]       move_dir;
  logic [RW-1:0]    row_nx;
  logic [CW-1:0]    col_nx;
  logic [NDOTS-1:0] mat_nx;

  assign dir    = {left, down, right, up};
  assign active = (state == RUN);

  dot_matrix_btn_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_btn (
    .clk        (clk),
    .reset      (reset),
    .enable     (active && power),
    .dir        (dir),
    .move_pulse (move_pulse),
    .move_dir   (move_dir)
  );

  always_comb begin
    state_nx = state;
    case (state)
      OFF:     state_nx = INIT;
      INIT:    state_nx = RUN;
      RUN:     state_nx = RUN;
      default: state_nx = INIT;
    endcase
  end

  // Non-power-of-2 sizes need the explicit last-index compares for wrapping.
  always_comb begin
    row_nx = row_pos;
    col_nx = col_pos;
    if (state != RUN) begin
      row_nx = '0;
      col_nx = '0;
    end else if (move_pulse) begin
      case (move_dir)
        DIR_UP: begin
          if (row_pos != '0)  row_nx = row_pos - 1'b1;
          else if (WRAP != 0) row_nx = ROW_LAST;
        end
        DIR_DOWN: begin
          if (row_pos != ROW_LAST) row_nx = row_pos + 1'b1;
          else if (WRAP != 0)      row_nx = '0;
        end
        DIR_LEFT: begin
          if (col_pos != '0)  col_nx = col_pos - 1'b1;
          else if (WRAP != 0) col_nx = COL_LAST;
        end
        DIR_RIGHT: begin
          if (col_pos != COL_LAST) col_nx = col_pos + 1'b1;
          else if (WRAP != 0)      col_nx = '0;
        end
        default: ;
      endcase
    end
    mat_nx = NDOTS'(1) << (int'(row_nx) * COLS + int'(col_nx));
  end

  // Power loss dominates reset, which dominates normal sequencing.
  always_ff @(posedge clk) begin
    if (!power) begin
      state   <= OFF;
      row_pos <= '0;
      col_pos <= '0;
      mat_out <= '0;
    end else if (reset) begin
      state   <= INIT;
      row_pos <= '0;
      col_pos <= '0;
      mat_out <= NDOTS'(1);
    end else begin
      state   <= state_nx;
      row_pos <= row_nx;
      col_pos <= col_nx;
      mat_out <= mat_nx;
    end
  end

endmodule

// File: tb/tb_dot_matrix_cursor.sv
// Bench for dot_matrix_cursor: two 4x6 instances (wrap+repeat, clamp+no-repeat)
// compared every cycle against an edge-counting behavioural model.
module tb_dot_matrix_cursor;

  localparam int ROWS = 4;
  localparam int COLS = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic power = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;

  logic [23:0] mat_a, mat_b;
  logic [1:0]  row_a, row_b;
  logic [2:0]  col_a, col_b;
  logic        act_a, act_b;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  // Model state per instance: phase 0=off 1=init 2=run; k = edges since press.
  int         m_phase[2];
  int         m_row[2];
  int         m_col[2];
  int         m_k[2];
  logic [3:0] m_prev[2];

  always #5 clk = ~clk;

  dot_matrix_cursor #(.ROWS(ROWS), .COLS(COLS), .WRAP(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)) dut_a (
    .clk(clk), .reset(reset), .power(power), .up(up), .down(down), .left(left), .right(right),
    .mat_out(mat_a), .row_pos(row_a), .col_pos(col_a), .active(act_a));

  dot_matrix_cursor #(.ROWS(ROWS), .COLS(COLS), .WRAP(0), .REPEAT_DELAY(0), .REPEAT_RATE(1)) dut_b (
    .clk(clk), .reset(reset), .power(power), .up(up), .down(down), .left(left), .right(right),
    .mat_out(mat_b), .row_pos(row_b), .col_pos(col_b), .active(act_b));

  function automatic int p_wrap(input int i);  return (i == 0) ? 1 : 0; endfunction
  function automatic int p_delay(input int i); return (i == 0) ? 4 : 0; endfunction
  function automatic int p_rate(input int i);  return (i == 0) ? 2 : 1; endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_move(input int i, input logic [3:0] d);
    bit w;
    w = (p_wrap(i) != 0);
    case (d)
      4'b0001: m_row[i] = w ? (m_row[i] + ROWS - 1) % ROWS : ((m_row[i] > 0) ? m_row[i] - 1 : m_row[i]);
      4'b0100: m_row[i] = w ? (m_row[i] + 1) % ROWS : ((m_row[i] < ROWS - 1) ? m_row[i] + 1 : m_row[i]);
      4'b1000: m_col[i] = w ? (m_col[i] + COLS - 1) % COLS : ((m_col[i] > 0) ? m_col[i] - 1 : m_col[i]);
      4'b0010: m_col[i] = w ? (m_col[i] + 1) % COLS : ((m_col[i] < COLS - 1) ? m_col[i] + 1 : m_col[i]);
      default: ;
    endcase
  endtask

  task automatic model_step(input int i);
    logic [3:0] d;
    bit valid;
    int pd, pr;
    d     = {left, down, right, up};
    valid = ($countones(d) == 1);
    pd    = p_delay(i);
    pr    = p_rate(i);
    if (!power) begin
      m_phase[i] = 0; m_row[i] = 0; m_col[i] = 0; m_k[i] = -1;
    end else if (reset || m_phase[i] == 0) begin
      m_phase[i] = 1; m_row[i] = 0; m_col[i] = 0; m_k[i] = -1;
    end else if (m_phase[i] == 1) begin
      m_phase[i] = 2; m_k[i] = -1;
    end else if (!valid) begin
      m_k[i] = -1;
    end else if (d != m_prev[i]) begin
      m_k[i] = 0;
      model_move(i, d);
    end else if (m_k[i] >= 0) begin
      m_k[i]++;
      if (pd > 0 && m_k[i] >= pd && ((m_k[i] - pd) % pr) == 0) model_move(i, d);
    end
    m_prev[i] = d;
  endtask

  function automatic logic [63:0] exp_mat(input int i);
    if (m_phase[i] == 0) return 64'd0;
    return 64'd1 << (m_row[i] * COLS + m_col[i]);
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      check("a.mat",    64'(mat_a), exp_mat(0));
      check("a.row",    64'(row_a), 64'(m_row[0]));
      check("a.col",    64'(col_a), 64'(m_col[0]));
      check("a.active", 64'(act_a), 64'(m_phase[0] == 2));
      check("b.mat",    64'(mat_b), exp_mat(1));
      check("b.row",    64'(row_b), 64'(m_row[1]));
      check("b.col",    64'(col_b), 64'(m_col[1]));
      check("b.active", 64'(act_b), 64'(m_phase[1] == 2));
    end
  end

  task automatic cyc(input bit p, input bit r, input bit u, input bit dn, input bit l, input bit rt);
    power = p; reset = r; up = u; down = dn; left = l; right = rt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic go_home();
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] cur;
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_row[i] = 0; m_col[i] = 0; m_k[i] = -1; m_prev[i] = 4'b0;
    end

    // Power off dominates reset.
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    check("off.mat", 64'(mat_a), 64'h0);
    check("off.active", 64'(act_a), 64'h0);

    cyc(1, 1, 0, 0, 0, 0);
    check("init.mat", 64'(mat_a), 64'h000001);
    check("init.row", 64'(row_a), 64'h0);
    check("init.active", 64'(act_a), 64'h0);
    cyc(1, 0, 0, 0, 0, 0);
    check("run.active", 64'(act_a), 64'h1);

    // Single press then hold: no repeat yet on A, none ever on B.
    cyc(1, 0, 0, 1, 0, 0);
    check("down.row_a", 64'(row_a), 64'h1);
    check("down.mat_a", 64'(mat_a), 64'h000040);
    check("down.row_b", 64'(row_b), 64'h1);
    for (int j = 0; j < 3; j++) cyc(1, 0, 0, 1, 0, 0);
    check("hold.row_b", 64'(row_b), 64'h1);
    check("hold.row_a", 64'(row_a), 64'h1);
    idle(1);

    // Edge behaviour: wrap on A, clamp on B.
    go_home();
    cyc(1, 0, 1, 0, 0, 0);
    idle(1);
    check("wrap.row_a", 64'(row_a), 64'h3);
    check("clamp.row_b", 64'(row_b), 64'h0);
    cyc(1, 0, 0, 0, 1, 0);
    idle(1);
    check("wrap.col_a", 64'(col_a), 64'h5);
    check("wrap.mat_a", 64'(mat_a), 64'h800000);
    check("clamp.mat_b", 64'(mat_b), 64'h000001);

    // Hold right 9 edges: A moves at P, P+4, P+6, P+8.
    go_home();
    for (int j = 0; j < 5; j++) cyc(1, 0, 0, 0, 0, 1);
    check("rep5.col_a", 64'(col_a), 64'h2);
    for (int j = 0; j < 4; j++) cyc(1, 0, 0, 0, 0, 1);
    check("rep9.col_a", 64'(col_a), 64'h4);
    check("rep9.col_b", 64'(col_b), 64'h1);
    idle(4);
    check("release.col_a", 64'(col_a), 64'h4);

    // Two buttons at once do nothing; dropping one is a fresh press.
    go_home();
    cyc(1, 0, 0, 1, 0, 0); idle(1);
    cyc(1, 0, 0, 1, 0, 0); idle(1);
    cyc(1, 0, 0, 0, 0, 1); idle(1);
    cyc(1, 0, 0, 0, 0, 1); idle(1);
    cyc(1, 0, 0, 1, 0, 1);
    cyc(1, 0, 0, 1, 0, 1);
    check("multi.row_a", 64'(row_a), 64'h2);
    check("multi.col_a", 64'(col_a), 64'h2);
    cyc(1, 0, 0, 0, 0, 1);
    check("newpress.col_a", 64'(col_a), 64'h3);
    check("newpress.col_b", 64'(col_b), 64'h3);
    check("newpress.mat_a", 64'(mat_a), 64'h008000);
    idle(1);

    // Power drop mid-repeat, then a held button must not move the dot.
    go_home();
    for (int j = 0; j < 6; j++) cyc(1, 0, 0, 0, 0, 1);
    check("prerun.col_a", 64'(col_a), 64'h2);
    cyc(0, 0, 0, 0, 0, 1);
    check("pwrdrop.mat_a", 64'(mat_a), 64'h0);
    check("pwrdrop.col_a", 64'(col_a), 64'h0);
    check("pwrdrop.active", 64'(act_a), 64'h0);
    cyc(1, 0, 0, 0, 0, 1);
    check("pwrup.mat_a", 64'(mat_a), 64'h000001);
    cyc(1, 0, 0, 0, 0, 1);
    check("pwrup.active", 64'(act_a), 64'h1);
    for (int j = 0; j < 8; j++) cyc(1, 0, 0, 0, 0, 1);
    check("heldthrough.col_a", 64'(col_a), 64'h0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 1);
    check("repress.col_a", 64'(col_a), 64'h1);
    idle(1);

    // Randomised traffic, biased toward long holds so repeats fire.
    cur = 4'b0;
    for (int n = 0; n < 2000; n++) begin
      bit p, r;
      int sel;
      p = ($urandom_range(0, 99) >= 2);
      r = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 12) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0, 1:    cur = 4'b0000;
          2:       cur = 4'b0001;
          3:       cur = 4'b0010;
          4:       cur = 4'b0100;
          5:       cur = 4'b1000;
          default: cur = 4'($urandom_range(0, 15));
        endcase
      end
      cyc(p, r, cur[0], cur[2], cur[3], cur[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_matrix_cursor.md
Name: dot_matrix_cursor

Overview:
Parametrised successor to the 4x4 single-dot matrix.
- Drives one lit dot on a ROWS x COLS LED matrix.
- The dot moves on up/down/left/right buttons, with press-edge detection, hold-to-repeat and a selectable wrap or clamp at the edges.
- Sits between the debounced button inputs and the matrix column/row driver; power gating blanks the display.

Parameters:
ROWS, 8, number of matrix rows (2..64)
COLS, 8, number of matrix columns (2..64)
WRAP, 1, 1 = wrap at edges modulo ROWS/COLS; 0 = clamp at edges
REPEAT_DELAY, 16, held cycles from the press move to the first repeat move; 0 disables repeat
REPEAT_RATE, 4, cycles between subsequent repeat moves (>=1)
RW/CW, derived localparams: $clog2(ROWS), $clog2(COLS), each minimum 1

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
power  in  1  1 = display enabled; 0 = forced OFF, overrides reset
up  in  1  move row -1
down  in  1  move row +1
left  in  1  move col -1
right  in  1  move col +1
mat_out  out  ROWS*COLS  bit r*COLS+c is the LED at (r,c); registered
row_pos  out  RW  current row; registered
col_pos  out  CW  current column; registered
active  out  1  1 when state is RUN

Behaviour:
- States (encodings fixed in package): OFF=4'hA, INIT=4'hF, RUN=4'h5. Register priority at each edge:
  - power=0 -> OFF
  - else reset=1 -> INIT
  - else OFF->INIT, INIT->RUN, RUN->RUN.
- OFF:
  - mat_out=0, row_pos=0, col_pos=0, active=0, repeat counter cleared.
  - These are also the values after power-up with power=0.
- INIT:
  - row_pos=0, col_pos=0, mat_out has only bit 0 set, active=0.
  - Lasts exactly one cycle unless reset is held.
- Reset:
  - reset with power=1 gives the INIT outputs at the next edge.
  - reset mid-repeat aborts the repeat.
  - reset with power=0 has no effect beyond OFF.
- Direction decode: dir = {left,down,right,up}.
  - Valid only if exactly one bit is set.
  - 0 or more than 1 bit set = no move; the repeat counter is cleared.
- prev_dir register:
  - Captures dir every cycle in every state.
  - A button held through INIT does not move the dot on entering RUN.
- Press move: in RUN, dir valid and dir != prev_dir -> move at that edge; counter cleared.
  - Changing directly from one valid direction to another is a new press.
- Repeat (REPEAT_DELAY>0): with the same valid dir held continuously after a press at edge P, moves occur at edges P+REPEAT_DELAY, then every REPEAT_RATE edges.
  - The counter width covers max(REPEAT_DELAY, REPEAT_RATE).
- Latency: inputs sampled at edge N; mat_out, row_pos and col_pos show the new position after edge N (one register stage). mat_out is always decoded from the next position, never one cycle stale.
- Arithmetic and edges:
  - Up decrements row, down increments row, left decrements col, right increments col.
  - WRAP=1: row 0 up -> ROWS-1; ROWS-1 down -> 0; same for columns. Non-power-of-2 sizes use explicit compares, not bit truncation.
  - WRAP=0: a move off an edge leaves the position unchanged. The repeat counter keeps running.
- mat_out invariant: in INIT and RUN exactly one bit is set; in OFF no bit is set.

Decomposition:
- Package dot_matrix_pkg:
  - state encodings OFF/INIT/RUN
  - direction one-hot constants DIR_UP=4'b0001, DIR_RIGHT=4'b0010, DIR_DOWN=4'b0100, DIR_LEFT=4'b1000
  - clog2 helper
- Sub-module dot_matrix_btn_repeat: prev_dir capture, validity check, press edge and hold counter.
  - Parameters: REPEAT_DELAY, REPEAT_RATE.
  - Outputs: move_pulse (1 cycle), move_dir (4 bits).
  - Inputs: clk, reset, enable (state==RUN).
- Top level holds the FSM, the position arithmetic and the one-hot decode.

Test Plan:
- ROWS=4, COLS=6, power=0 with reset toggling -> mat_out=0, active=0. power=1, reset=1 one cycle -> mat_out=24'h000001, row_pos=0. Two edges later -> active=1.
- RUN at (0,0): down pulsed 1 cycle -> (1,0), mat_out bit 6. Same down held 3 more cycles with REPEAT_DELAY=0 -> still (1,0), no repeat.
- WRAP=1, at (0,0): up press -> (3,0); left press -> (3,5), mat_out bit 23. WRAP=0, at (0,0): up and left presses -> stays (0,0).
- REPEAT_DELAY=4, REPEAT_RATE=2, at (0,0): right held 9 cycles from press edge P -> moves at P, P+4, P+6, P+8, ending at col 4. Release -> no further moves.
- At (2,2): down+right asserted together -> no move. Then down released, right still held -> counts as a new press, (2,3).
- During an auto-repeat: power dropped -> mat_out=0 next edge, position 0. power restored with right still held -> INIT then RUN at (0,0), no move until right is released and pressed again.
